// File: rtl/idli_fetch_if.sv
// Fetch-unit bus bundle: SQI SRAM pins, backend control and decoder nibble stream.
// master = fetch sequencer, slave = SRAM pads / decoder / execute side.
interface idli_fetch_if;
  logic        o_fch_sqi_cs_n;
  logic        o_fch_sqi_sck_en;
  logic        o_fch_sqi_oe;
  logic [3:0]  o_fch_sqi_data;
  logic [3:0]  i_fch_sqi_data;
  logic        i_fch_stall;
  logic        i_fch_redirect;
  logic [15:0] i_fch_redirect_pc;
  logic [3:0]  o_dcd_enc;
  logic        o_dcd_enc_vld;
  logic [15:0] o_fch_pc;

  modport master (
    output o_fch_sqi_cs_n, o_fch_sqi_sck_en, o_fch_sqi_oe, o_fch_sqi_data,
    output o_dcd_enc, o_dcd_enc_vld, o_fch_pc,
    input  i_fch_sqi_data, i_fch_stall, i_fch_redirect, i_fch_redirect_pc
  );

  modport slave (
    input  o_fch_sqi_cs_n, o_fch_sqi_sck_en, o_fch_sqi_oe, o_fch_sqi_data,
    input  o_dcd_enc, o_dcd_enc_vld, o_fch_pc,
    output i_fch_sqi_data, i_fch_stall, i_fch_redirect, i_fch_redirect_pc
  );
endinterface

// File: rtl/idli_fetch_m.sv
// Instruction fetch sequencer: issues a quad-mode SQI read burst and streams
// the returned nibbles, MSB first, to the decoder; redirects restart the burst.
module idli_fetch_m #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter logic [7:0]  RD_CMD        = 8'h03,
  parameter int          DUMMY_NIBBLES = 2
) (
  input  logic         i_dcd_gck,
  input  logic         i_dcd_rst_n,
  idli_fetch_if.master fch
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4
  } state_t;

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_NIBBLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] r_fetch_pc;
  logic [15:0] r_pc;
  logic [1:0]  r_idx;
  logic [3:0]  r_enc;
  logic        r_vld;
  logic        w_sample;
  logic [23:0] w_addr;
  logic [3:0]  w_addr_nib [8];

  // Byte address of the word PC, split into nibbles indexed by the phase counter.
  assign w_addr = {7'b0, r_fetch_pc, 1'b0};
  for (genvar gi = 0; gi < 8; gi++) begin : g_addr_nib
    if (gi < 6) begin : g_nib
      assign w_addr_nib[gi] = w_addr[23-4*gi -: 4];
    end else begin : g_pad
      assign w_addr_nib[gi] = 4'h0;
    end
  end

  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 3'd1;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_CMD;
        w_cnt_nxt   = 3'd0;
      end
      ST_CMD: if (r_cnt == 3'd1) begin
        w_state_nxt = ST_ADDR;
        w_cnt_nxt   = 3'd0;
      end
      ST_ADDR: if (r_cnt == 3'd5) begin
        w_state_nxt = ST_DUMMY;
        w_cnt_nxt   = 3'd0;
      end
      ST_DUMMY: if (r_cnt == DUMMY_LAST) begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = 3'd0;
      end
      ST_DATA: w_cnt_nxt = 3'd0;
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
    if (fch.i_fch_redirect) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
    end
  end

  always_comb begin
    fch.o_fch_sqi_cs_n   = 1'b1;
    fch.o_fch_sqi_sck_en = 1'b0;
    fch.o_fch_sqi_oe     = 1'b0;
    fch.o_fch_sqi_data   = 4'h0;
    case (r_state)
      ST_CMD: begin
        fch.o_fch_sqi_cs_n   = 1'b0;
        fch.o_fch_sqi_sck_en = 1'b1;
        fch.o_fch_sqi_oe     = 1'b1;
        fch.o_fch_sqi_data   = r_cnt[0] ? RD_CMD[3:0] : RD_CMD[7:4];
      end
      ST_ADDR: begin
        fch.o_fch_sqi_cs_n   = 1'b0;
        fch.o_fch_sqi_sck_en = 1'b1;
        fch.o_fch_sqi_oe     = 1'b1;
        fch.o_fch_sqi_data   = w_addr_nib[r_cnt];
      end
      ST_DUMMY: begin
        fch.o_fch_sqi_cs_n   = 1'b0;
        fch.o_fch_sqi_sck_en = 1'b1;
      end
      ST_DATA: begin
        fch.o_fch_sqi_cs_n   = 1'b0;
        fch.o_fch_sqi_sck_en = ~fch.i_fch_stall;
      end
      default: ;
    endcase
  end

  assign w_sample = (r_state == ST_DATA) && !fch.i_fch_stall && !fch.i_fch_redirect;

  // r_pc tags the nibble being presented; r_fetch_pc tracks the nibble being sampled.
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      r_enc      <= 4'h0;
      r_vld      <= 1'b0;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_idx      <= 2'd0;
    end else if (fch.i_fch_redirect) begin
      r_vld      <= 1'b0;
      r_pc       <= fch.i_fch_redirect_pc;
      r_fetch_pc <= fch.i_fch_redirect_pc;
      r_idx      <= 2'd0;
    end else if (w_sample) begin
      r_enc <= fch.i_fch_sqi_data;
      r_vld <= 1'b1;
      r_pc  <= r_fetch_pc;
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_fetch_pc <= r_fetch_pc + 16'd1;
      end
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign fch.o_dcd_enc     = r_enc;
  assign fch.o_dcd_enc_vld = r_vld;
  assign fch.o_fch_pc      = r_pc;

endmodule
